// File: rtl/df_pkg.sv
// rtl/df_pkg.sv - shared widths, Q0.8 coefficients and FSM encoding for the 4-tap FIR sequencer
package df_pkg;

  localparam int DF_DATA_W = 8;
  localparam int DF_NTAPS  = 4;
  localparam int DF_ACC_W  = 10;

  // Unsigned Q0.8 taps; they sum to 256 so the DC gain is unity.
  localparam logic [DF_DATA_W-1:0] DF_COEF [0:DF_NTAPS-1] = '{8'h1B, 8'h65, 8'h65, 8'h1B};

  typedef enum logic [1:0] {
    DF_IDLE = 2'd0,
    DF_MAC  = 2'd1,
    DF_DONE = 2'd2
  } df_state_t;

endpackage

// File: rtl/df_mac.sv
// rtl/df_mac.sv - combinational tap product (optional DF_ROUND_EN rounding) with saturating accumulate
module df_mac
  import df_pkg::*;
#(
  parameter int DATA_W = DF_DATA_W,
  parameter int ACC_W  = DF_ACC_W
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_coef,
  input  logic [ACC_W-1:0]  i_acc,
  output logic [ACC_W-1:0]  o_acc
);

  logic [2*DATA_W-1:0] w_prod_full;
  logic [2*DATA_W-1:0] w_prod_rnd;
  logic [2*DATA_W-1:0] w_prod_sh;
  logic [ACC_W:0]      w_sum;

  assign w_prod_full = i_x * i_coef;

`ifdef DF_ROUND_EN
  // Round half up before dropping the fractional byte.
  assign w_prod_rnd = w_prod_full + (2*DATA_W)'(1 << (DATA_W - 1));
`else
  assign w_prod_rnd = w_prod_full;
`endif

  assign w_prod_sh = w_prod_rnd >> DATA_W;
  assign w_sum     = {1'b0, i_acc} + (ACC_W + 1)'(w_prod_sh);
  assign o_acc     = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

endmodule

// File: rtl/df_fir_sequencer.sv
// rtl/df_fir_sequencer.sv - time-multiplexed FIR: delay line, tap sequencing FSM, output register
// Rounding of each tap product is selected by DF_ROUND_EN inside df_mac.
module df_fir_sequencer
  import df_pkg::*;
#(
  parameter int DATA_W = DF_DATA_W,
  parameter int NTAPS  = DF_NTAPS,
  parameter int ACC_W  = DF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(NTAPS);

  df_state_t r_state;
  df_state_t w_state_next;

  logic [DATA_W-1:0] r_delay [0:NTAPS-1];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_k;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_out_data;

  logic [PTR_W-1:0]  w_tap_addr;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_last_tap;
  logic              w_accept;

  // wr_ptr already points past the newest sample, so tap k reads wr_ptr-1-k.
  assign w_tap_addr = r_wr_ptr - PTR_W'(1) - r_k;
  assign w_last_tap = (r_k == PTR_W'(NTAPS - 1));
  assign w_accept   = (r_state == DF_IDLE) && in_valid;

  df_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_x   (r_delay[w_tap_addr]),
    .i_coef(DATA_W'(DF_COEF[r_k])),
    .i_acc (r_acc),
    .o_acc (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DF_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DF_IDLE: if (in_valid)   w_state_next = DF_MAC;
      DF_MAC:  if (w_last_tap) w_state_next = DF_DONE;
      DF_DONE: if (out_ready)  w_state_next = DF_IDLE;
      default:                 w_state_next = DF_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      DF_IDLE: in_ready = 1'b1;
      DF_MAC:  busy     = 1'b1;
      DF_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) r_delay[i] <= '0;
      r_wr_ptr   <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (w_accept) begin
      r_delay[r_wr_ptr] <= in_data;
      r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      r_acc             <= '0;
      r_k               <= '0;
    end else if (r_state == DF_MAC) begin
      r_acc <= w_acc_next;
      r_k   <= r_k + PTR_W'(1);
      if (w_last_tap) begin
        r_out_data <= (w_acc_next > ACC_W'((1 << DATA_W) - 1)) ? '1 : w_acc_next[DATA_W-1:0];
      end
    end
  end

  assign out_data = r_out_data;

endmodule
